mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-client memory arbiter: merges instruction fetch and data ports onto one
// registered physical memory port, data-priority with a fetch starvation limit.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [15:0] if_memaddr,
    input  logic [1:0]  if_mem_byte_enable,
    input  logic        if_memread,
    output logic [15:0] if_mem_rdata,
    output logic        if_mem_resp,

    input  logic [15:0] mem_memaddr,
    input  logic [1:0]  mem_mem_byte_enable,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    input  logic [15:0] mem_mem_wdata,
    output logic [15:0] mem_mem_rdata,
    output logic        mem_mem_resp,

    output logic [15:0] pmem_address,
    output logic [1:0]  pmem_byte_enable,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_wdata,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic       grant;
    logic [3:0] starve_cnt;
    logic [3:0] starve_next;
    logic       data_req;
    logic       fetch_req;
    logic       grant_data;
    logic       grant_fetch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Data wins unless a waiting fetch has already been passed over LIMIT times.
    always_comb begin
        state_next  = state;
        starve_next = starve_cnt;
        grant_data  = 1'b0;
        grant_fetch = 1'b0;
        data_req    = mem_memread | mem_memwrite;
        fetch_req   = if_memread;
        case (state)
            IDLE: begin
                if (data_req && (!fetch_req || (starve_cnt < LIMIT))) begin
                    grant_data  = 1'b1;
                    starve_next = fetch_req ? starve_cnt + 4'd1 : 4'd0;
                    state_next  = BUSY;
                end else if (fetch_req) begin
                    grant_fetch = 1'b1;
                    starve_next = 4'd0;
                    state_next  = BUSY;
                end
            end
            BUSY:    if (pmem_resp) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant            <= 1'b0;
            starve_cnt       <= 4'd0;
            pmem_address     <= '0;
            pmem_byte_enable <= '0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_wdata       <= '0;
            if_mem_rdata     <= '0;
            if_mem_resp      <= 1'b0;
            mem_mem_rdata    <= '0;
            mem_mem_resp     <= 1'b0;
        end else begin
            if_mem_resp  <= 1'b0;
            mem_mem_resp <= 1'b0;
            starve_cnt   <= starve_next;
            // A data request with both strobes set is treated as a write.
            if (grant_data) begin
                grant            <= 1'b1;
                pmem_address     <= mem_memaddr;
                pmem_byte_enable <= mem_mem_byte_enable;
                pmem_wdata       <= mem_mem_wdata;
                pmem_write       <= mem_memwrite;
                pmem_read        <= mem_memread & ~mem_memwrite;
            end else if (grant_fetch) begin
                grant            <= 1'b0;
                pmem_address     <= if_memaddr;
                pmem_byte_enable <= if_mem_byte_enable;
                pmem_wdata       <= '0;
                pmem_write       <= 1'b0;
                pmem_read        <= 1'b1;
            end
            if ((state == BUSY) && pmem_resp) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
                if (grant) begin
                    mem_mem_resp  <= 1'b1;
                    mem_mem_rdata <= pmem_read ? pmem_rdata : 16'h0000;
                end else begin
                    if_mem_resp  <= 1'b1;
                    if_mem_rdata <= pmem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch/data service, priority,
// starvation limit, read latching, reset mid-transaction, write-wins violation.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [15:0] if_memaddr;
    logic [1:0]  if_mem_byte_enable;
    logic        if_memread;
    logic [15:0] if_mem_rdata;
    logic        if_mem_resp;
    logic [15:0] mem_memaddr;
    logic [1:0]  mem_mem_byte_enable;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [15:0] mem_mem_wdata;
    logic [15:0] mem_mem_rdata;
    logic        mem_mem_resp;
    logic [15:0] pmem_address;
    logic [1:0]  pmem_byte_enable;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .if_memaddr          (if_memaddr),
        .if_mem_byte_enable  (if_mem_byte_enable),
        .if_memread          (if_memread),
        .if_mem_rdata        (if_mem_rdata),
        .if_mem_resp         (if_mem_resp),
        .mem_memaddr         (mem_memaddr),
        .mem_mem_byte_enable (mem_mem_byte_enable),
        .mem_memread         (mem_memread),
        .mem_memwrite        (mem_memwrite),
        .mem_mem_wdata       (mem_mem_wdata),
        .mem_mem_rdata       (mem_mem_rdata),
        .mem_mem_resp        (mem_mem_resp),
        .pmem_address        (pmem_address),
        .pmem_byte_enable    (pmem_byte_enable),
        .pmem_read           (pmem_read),
        .pmem_write          (pmem_write),
        .pmem_wdata          (pmem_wdata),
        .pmem_rdata          (pmem_rdata),
        .pmem_resp           (pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pmem_address"}, pmem_address, 16'h0000);
        check({tag, "_pmem_be"}, {14'd0, pmem_byte_enable}, 16'h0000);
        check({tag, "_pmem_read"}, {15'd0, pmem_read}, 16'h0000);
        check({tag, "_pmem_write"}, {15'd0, pmem_write}, 16'h0000);
        check({tag, "_pmem_wdata"}, pmem_wdata, 16'h0000);
        check({tag, "_if_resp"}, {15'd0, if_mem_resp}, 16'h0000);
        check({tag, "_if_rdata"}, if_mem_rdata, 16'h0000);
        check({tag, "_mem_resp"}, {15'd0, mem_mem_resp}, 16'h0000);
        check({tag, "_mem_rdata"}, mem_mem_rdata, 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0;
        if_memaddr = '0; if_mem_byte_enable = '0; if_memread = 1'b0;
        mem_memaddr = '0; mem_mem_byte_enable = '0; mem_memread = 1'b0;
        mem_memwrite = 1'b0; mem_mem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        step();
        check_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // Fetch-only read, two wait cycles before pmem_resp
        $display("[TB] fetch read");
        if_memaddr = 16'h3000; if_mem_byte_enable = 2'b11; if_memread = 1'b1;
        step();
        check("t1_read_c1", {15'd0, pmem_read}, 16'd1);
        check("t1_addr", pmem_address, 16'h3000);
        check("t1_be", {14'd0, pmem_byte_enable}, 16'd3);
        check("t1_write", {15'd0, pmem_write}, 16'd0);
        step();
        check("t1_read_c2", {15'd0, pmem_read}, 16'd1);
        step();
        check("t1_read_c3", {15'd0, pmem_read}, 16'd1);
        pmem_resp = 1'b1; pmem_rdata = 16'h1234;
        step();
        pmem_resp = 1'b0; pmem_rdata = 16'h0000;
        check("t1_read_drop", {15'd0, pmem_read}, 16'd0);
        check("t1_if_resp", {15'd0, if_mem_resp}, 16'd1);
        check("t1_if_rdata", if_mem_rdata, 16'h1234);
        check("t1_mem_resp", {15'd0, mem_mem_resp}, 16'd0);
        if_memread = 1'b0;
        step();
        check("t1_if_resp_end", {15'd0, if_mem_resp}, 16'd0);

        // Simultaneous fetch and data write: data first, fetch at R+2
        $display("[TB] simultaneous requests");
        if_memaddr = 16'h0040; if_memread = 1'b1;
        mem_memaddr = 16'h8000; mem_memwrite = 1'b1; mem_mem_wdata = 16'hBEEF;
        mem_mem_byte_enable = 2'b01;
        step();
        check("t2_write", {15'd0, pmem_write}, 16'd1);
        check("t2_read", {15'd0, pmem_read}, 16'd0);
        check("t2_addr", pmem_address, 16'h8000);
        check("t2_be", {14'd0, pmem_byte_enable}, 16'd1);
        check("t2_wdata", pmem_wdata, 16'hBEEF);
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        check("t2_mem_resp", {15'd0, mem_mem_resp}, 16'd1);
        check("t2_mem_rdata", mem_mem_rdata, 16'h0000);
        check("t2_if_resp_early", {15'd0, if_mem_resp}, 16'd0);
        check("t2_write_drop", {15'd0, pmem_write}, 16'd0);
        mem_memwrite = 1'b0;
        step();
        check("t2_mem_resp_end", {15'd0, mem_mem_resp}, 16'd0);
        check("t2_turnaround", {15'd0, pmem_read}, 16'd0);
        step();
        check("t2_fetch_read", {15'd0, pmem_read}, 16'd1);
        check("t2_fetch_addr", pmem_address, 16'h0040);
        pmem_resp = 1'b1; pmem_rdata = 16'h5555;
        step();
        pmem_resp = 1'b0;
        check("t2_if_resp", {15'd0, if_mem_resp}, 16'd1);
        check("t2_if_rdata", if_mem_rdata, 16'h5555);
        check("t2_mem_resp_quiet", {15'd0, mem_mem_resp}, 16'd0);
        if_memread = 1'b0;
        step();
        check("t2_if_resp_end", {15'd0, if_mem_resp}, 16'd0);

        // Starvation: four data grants then the waiting fetch
        $display("[TB] starvation limit");
        if_memaddr = 16'h0100; if_memread = 1'b1;
        mem_memaddr = 16'h9000; mem_memread = 1'b1; mem_mem_byte_enable = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t3_data_addr%0d", i), pmem_address, 16'h9000 + 16'(i));
            check($sformatf("t3_data_read%0d", i), {15'd0, pmem_read}, 16'd1);
            pmem_resp = 1'b1; pmem_rdata = 16'h0A00 + 16'(i);
            step();
            pmem_resp = 1'b0;
            check($sformatf("t3_mem_resp%0d", i), {15'd0, mem_mem_resp}, 16'd1);
            check($sformatf("t3_mem_rdata%0d", i), mem_mem_rdata, 16'h0A00 + 16'(i));
            check($sformatf("t3_if_quiet%0d", i), {15'd0, if_mem_resp}, 16'd0);
            mem_memaddr = 16'h9000 + 16'(i + 1);
            step();
        end
        step();
        check("t3_fetch_addr", pmem_address, 16'h0100);
        check("t3_fetch_read", {15'd0, pmem_read}, 16'd1);
        check("t3_starve_clear", {12'd0, dut.starve_cnt}, 16'd0);
        mem_memread = 1'b0;
        pmem_resp = 1'b1; pmem_rdata = 16'h0F0F;
        step();
        pmem_resp = 1'b0;
        check("t3_if_resp", {15'd0, if_mem_resp}, 16'd1);
        check("t3_if_rdata", if_mem_rdata, 16'h0F0F);
        if_memread = 1'b0;
        step();

        // Read latch: pmem_rdata changes during DONE, address stable in BUSY
        $display("[TB] read latch");
        mem_memaddr = 16'h2222; mem_memread = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t4_addr_busy%0d", i), pmem_address, 16'h2222);
        end
        pmem_resp = 1'b1; pmem_rdata = 16'hA5A5;
        step();
        pmem_resp = 1'b0; pmem_rdata = 16'hFFFF;
        #2;
        check("t4_mem_resp", {15'd0, mem_mem_resp}, 16'd1);
        check("t4_mem_rdata", mem_mem_rdata, 16'hA5A5);
        mem_memread = 1'b0;
        step();
        check("t4_mem_resp_end", {15'd0, mem_mem_resp}, 16'd0);

        // Protocol violation: read and write together, write wins
        $display("[TB] read+write violation");
        mem_memaddr = 16'h6666; mem_memread = 1'b1; mem_memwrite = 1'b1;
        mem_mem_wdata = 16'hCAFE;
        step();
        check("t6_write", {15'd0, pmem_write}, 16'd1);
        check("t6_read", {15'd0, pmem_read}, 16'd0);
        check("t6_wdata", pmem_wdata, 16'hCAFE);
        pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
        step();
        pmem_resp = 1'b0;
        check("t6_mem_resp", {15'd0, mem_mem_resp}, 16'd1);
        check("t6_mem_rdata", mem_mem_rdata, 16'h0000);
        mem_memread = 1'b0; mem_memwrite = 1'b0;
        step();

        // Reset mid-BUSY, then a late pmem_resp
        $display("[TB] reset mid-busy");
        mem_memaddr = 16'h4444; mem_memwrite = 1'b1; mem_mem_wdata = 16'h1111;
        step();
        check("t5_write", {15'd0, pmem_write}, 16'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        mem_memwrite = 1'b0;
        step();
        step();
        rst_n = 1'b1; pmem_resp = 1'b1; pmem_rdata = 16'h9999;
        step();
        check("t5_late_mem_resp", {15'd0, mem_mem_resp}, 16'd0);
        check("t5_late_if_resp", {15'd0, if_mem_resp}, 16'd0);
        pmem_resp = 1'b0;
        step();
        check("t5_late_mem_resp2", {15'd0, mem_mem_resp}, 16'd0);
        check("t5_late_strobe", {15'd0, pmem_write}, 16'd0);
        if_memaddr = 16'h0200; if_memread = 1'b1;
        step();
        check("t5_next_read", {15'd0, pmem_read}, 16'd1);
        check("t5_next_addr", pmem_address, 16'h0200);
        pmem_resp = 1'b1; pmem_rdata = 16'h7777;
        step();
        pmem_resp = 1'b0;
        check("t5_next_if_resp", {15'd0, if_mem_resp}, 16'd1);
        check("t5_next_if_rdata", if_mem_rdata, 16'h7777);
        if_memread = 1'b0;
        step();
        check("t5_next_if_resp_end", {15'd0, if_mem_resp}, 16'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
